// File: rtl/alu_flag_stage_if.sv
// Handshake and status bundle between the ALU, the flag stage and its consumer.
interface alu_flag_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_cout;
  logic [1:0]  in_op;
  logic        in_binv;
  logic        in_a_msb;
  logic        in_b_msb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        sticky_c;
  logic        sticky_v;
  logic        clr_sticky;
  logic [15:0] xfer_count;

  modport master (
    output in_valid, in_result, in_cout, in_op, in_binv, in_a_msb, in_b_msb,
    output out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_flags, sticky_c, sticky_v, xfer_count
  );

  modport slave (
    input  in_valid, in_result, in_cout, in_op, in_binv, in_a_msb, in_b_msb,
    input  out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_flags, sticky_c, sticky_v, xfer_count
  );
endinterface

// File: rtl/alu_flag_stage.sv
// ALU output stage: NZCV decode into a 2-entry skid buffer; 1-cycle latency, full rate.
// Backpressure: holds two words under out_ready=0; in_ready is purely registered.
module alu_flag_stage (
  input  logic              clk,
  input  logic              reset,
  alu_flag_stage_if.slave   bus
);

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;   // {N,Z,C,V}
  } word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  word_t       main_q, main_d;
  word_t       skid_q, skid_d;
  logic        sticky_c_q, sticky_c_d;
  logic        sticky_v_q, sticky_v_d;
  logic [15:0] xfer_count_q, xfer_count_d;

  word_t in_word;
  logic  accept;
  logic  xfer;
  logic  is_add;
  logic  ovf;

  always_comb begin
    is_add = (bus.in_op == 2'b10);
    // Subtract inverts b, so the same-sign test flips to a different-sign test.
    ovf = ((bus.in_a_msb ^ bus.in_b_msb) == bus.in_binv) &&
          (bus.in_result[31] != bus.in_a_msb);
    in_word.result = bus.in_result;
    in_word.flags  = {bus.in_result[31],
                      (bus.in_result == 32'd0),
                      is_add & bus.in_cout,
                      is_add & ovf};
  end

  assign bus.in_ready   = (state_q != FULL);
  assign bus.out_valid  = state_q[0];
  assign bus.out_result = main_q.result;
  assign bus.out_flags  = main_q.flags;
  assign bus.sticky_c   = sticky_c_q;
  assign bus.sticky_v   = sticky_v_q;
  assign bus.xfer_count = xfer_count_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign xfer   = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_word;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          main_d = in_word;
        end else if (accept) begin
          skid_d  = in_word;
          state_d = FULL;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A transfer in the same cycle as a clear still records its C/V.
  always_comb begin
    sticky_c_d   = (sticky_c_q & ~bus.clr_sticky) | (xfer & main_q.flags[1]);
    sticky_v_d   = (sticky_v_q & ~bus.clr_sticky) | (xfer & main_q.flags[0]);
    xfer_count_d = xfer ? xfer_count_q + 16'd1 : xfer_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      sticky_c_q   <= 1'b0;
      sticky_v_q   <= 1'b0;
      xfer_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      sticky_c_q   <= sticky_c_d;
      sticky_v_q   <= sticky_v_d;
      xfer_count_q <= xfer_count_d;
    end
  end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed bench for alu_flag_stage: flag decode, sticky bits, skid backpressure, counter wrap, reset.
module tb_alu_flag_stage;

  logic clk = 1'b0;
  logic reset;
  int   cmp  = 0;
  int   mism = 0;

  alu_flag_stage_if bus();

  alu_flag_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic co,
                       input logic [1:0] op, input logic bi, input logic am,
                       input logic bm);
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_cout   = co;
    bus.in_op     = op;
    bus.in_binv   = bi;
    bus.in_a_msb  = am;
    bus.in_b_msb  = bm;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    cmp++; if (bus.out_valid !== 1'b0) begin mism++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    cmp++; if (bus.in_ready !== 1'b1) begin mism++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    cmp++; if (bus.out_result !== 32'h0) begin mism++; $display("FAIL reset_out_result got=%h exp=0", bus.out_result); end
    cmp++; if (bus.out_flags !== 4'h0) begin mism++; $display("FAIL reset_out_flags got=%b exp=0000", bus.out_flags); end
    cmp++; if ({bus.sticky_c, bus.sticky_v} !== 2'b00) begin mism++; $display("FAIL reset_sticky got=%b exp=00", {bus.sticky_c, bus.sticky_v}); end
    cmp++; if (bus.xfer_count !== 16'h0) begin mism++; $display("FAIL reset_xfer_count got=%h exp=0000", bus.xfer_count); end
  endtask

  task automatic test_flag_decode();
    logic [31:0] res [4];
    logic [1:0]  ops [4];
    logic [3:0]  exp_f [4];
    res[0] = 32'h00000000; ops[0] = 2'b00; exp_f[0] = 4'b0100;
    res[1] = 32'hFFFFFFFF; ops[1] = 2'b01; exp_f[1] = 4'b1000;
    res[2] = 32'hFFFFFFFF; ops[2] = 2'b10; exp_f[2] = 4'b1000;
    res[3] = 32'h00000001; ops[3] = 2'b11; exp_f[3] = 4'b0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, res[i], 1'b0, ops[i], 1'b0, 1'b1, 1'b0);
      step();
      cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== res[i]) begin mism++; $display("FAIL decode_result[%0d] got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_result, res[i]); end
      cmp++; if (bus.out_flags !== exp_f[i]) begin mism++; $display("FAIL decode_flags[%0d] got=%b exp=%b", i, bus.out_flags, exp_f[i]); end
      cmp++; if (bus.in_ready !== 1'b1) begin mism++; $display("FAIL decode_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
    end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if (bus.out_valid !== 1'b0) begin mism++; $display("FAIL decode_drain_valid got=%b exp=0", bus.out_valid); end
    cmp++; if (bus.xfer_count !== 16'd4) begin mism++; $display("FAIL decode_xfer_count got=%0d exp=4", bus.xfer_count); end
    cmp++; if ({bus.sticky_c, bus.sticky_v} !== 2'b00) begin mism++; $display("FAIL decode_sticky got=%b exp=00", {bus.sticky_c, bus.sticky_v}); end
  endtask

  task automatic test_subtract();
    drive(1'b1, 32'hFFFFFFFE, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    step();
    cmp++; if (bus.out_result !== 32'hFFFFFFFE || bus.out_flags !== 4'b1010) begin mism++; $display("FAIL sub_word got=%h/%b exp=fffffffe/1010", bus.out_result, bus.out_flags); end
    cmp++; if (bus.sticky_c !== 1'b0) begin mism++; $display("FAIL sub_sticky_early got=%b exp=0", bus.sticky_c); end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if ({bus.sticky_c, bus.sticky_v} !== 2'b10) begin mism++; $display("FAIL sub_sticky got=%b exp=10", {bus.sticky_c, bus.sticky_v}); end
    cmp++; if (bus.xfer_count !== 16'd5) begin mism++; $display("FAIL sub_xfer_count got=%0d exp=5", bus.xfer_count); end
  endtask

  task automatic test_overflow();
    drive(1'b1, 32'h80000000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if (bus.out_result !== 32'h80000000 || bus.out_flags !== 4'b1001) begin mism++; $display("FAIL add_ovf_word got=%h/%b exp=80000000/1001", bus.out_result, bus.out_flags); end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if ({bus.sticky_c, bus.sticky_v} !== 2'b11) begin mism++; $display("FAIL add_ovf_sticky got=%b exp=11", {bus.sticky_c, bus.sticky_v}); end
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
    cmp++; if ({bus.sticky_c, bus.sticky_v} !== 2'b00) begin mism++; $display("FAIL clear_sticky got=%b exp=00", {bus.sticky_c, bus.sticky_v}); end
    drive(1'b1, 32'h7FFFFFFF, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    step();
    cmp++; if (bus.out_result !== 32'h7FFFFFFF || bus.out_flags !== 4'b0011) begin mism++; $display("FAIL sub_ovf_word got=%h/%b exp=7fffffff/0011", bus.out_result, bus.out_flags); end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
    cmp++; if ({bus.sticky_c, bus.sticky_v} !== 2'b11) begin mism++; $display("FAIL clr_vs_set got=%b exp=11", {bus.sticky_c, bus.sticky_v}); end
    cmp++; if (bus.xfer_count !== 16'd7) begin mism++; $display("FAIL ovf_xfer_count got=%0d exp=7", bus.xfer_count); end
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h11111111 || bus.in_ready !== 1'b1) begin mism++; $display("FAIL bp_w1 got=%b/%h/%b exp=1/11111111/1", bus.out_valid, bus.out_result, bus.in_ready); end
    drive(1'b1, 32'h00000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if (bus.in_ready !== 1'b0 || bus.out_result !== 32'h11111111) begin mism++; $display("FAIL bp_w2 got=%b/%h exp=0/11111111", bus.in_ready, bus.out_result); end
    drive(1'b1, 32'h80000000, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      cmp++; if (bus.in_ready !== 1'b0 || bus.out_result !== 32'h11111111 || bus.out_flags !== 4'b0000) begin mism++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=0/11111111/0000", i, bus.in_ready, bus.out_result, bus.out_flags); end
    end
    bus.out_ready = 1'b1;
    step();
    cmp++; if (bus.out_result !== 32'h00000000 || bus.out_flags !== 4'b0100 || bus.in_ready !== 1'b1) begin mism++; $display("FAIL bp_out_w2 got=%h/%b/%b exp=00000000/0100/1", bus.out_result, bus.out_flags, bus.in_ready); end
    step();
    cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h80000000 || bus.out_flags !== 4'b1000) begin mism++; $display("FAIL bp_out_w3 got=%b/%h/%b exp=1/80000000/1000", bus.out_valid, bus.out_result, bus.out_flags); end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if (bus.out_valid !== 1'b0 || bus.xfer_count !== 16'd10) begin mism++; $display("FAIL bp_drain got=%b/%0d exp=0/10", bus.out_valid, bus.xfer_count); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) step();
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if (bus.xfer_count !== 16'hFFFF) begin mism++; $display("FAIL wrap_preload got=%h exp=ffff", bus.xfer_count); end
    drive(1'b1, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if (bus.xfer_count !== 16'h0000) begin mism++; $display("FAIL wrap_rollover got=%h exp=0000", bus.xfer_count); end
  endtask

  task automatic test_reset_full();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h00000005, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if (bus.sticky_c !== 1'b1 || bus.xfer_count !== 16'd1) begin mism++; $display("FAIL prefull_state got=%b/%0d exp=1/1", bus.sticky_c, bus.xfer_count); end
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hAAAA0001, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hAAAA0002, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    cmp++; if (bus.in_ready !== 1'b0) begin mism++; $display("FAIL full_before_reset got=%b exp=0", bus.in_ready); end
    reset = 1'b1;
    bus.clr_sticky = 1'b0;
    drive(1'b1, 32'hAAAA0003, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin mism++; $display("FAIL rst_full_hs got=%b/%b exp=0/1", bus.out_valid, bus.in_ready); end
    cmp++; if (bus.out_result !== 32'h0 || bus.out_flags !== 4'h0) begin mism++; $display("FAIL rst_full_data got=%h/%b exp=0/0000", bus.out_result, bus.out_flags); end
    cmp++; if ({bus.sticky_c, bus.sticky_v} !== 2'b00 || bus.xfer_count !== 16'h0) begin mism++; $display("FAIL rst_full_status got=%b/%h exp=00/0000", {bus.sticky_c, bus.sticky_v}, bus.xfer_count); end
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hCAFEF00D, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hCAFEF00D || bus.out_flags !== 4'b1000) begin mism++; $display("FAIL post_reset_word got=%b/%h/%b exp=1/cafef00d/1000", bus.out_valid, bus.out_result, bus.out_flags); end
    step();
    cmp++; if (bus.out_valid !== 1'b0 || bus.xfer_count !== 16'd1) begin mism++; $display("FAIL post_reset_drain got=%b/%0d exp=0/1", bus.out_valid, bus.xfer_count); end
  endtask

  initial begin
    test_reset();
    test_flag_decode();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
